// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
//   uart_state_t  : frame FSM encoding (IDLE/START/DATA/STOP)
//   OVERSAMPLE    : ticks per bit period
//   MID_TICK      : tick index that lands mid start bit
//   DEFAULT_DBITS : default data bits per frame
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int OVERSAMPLE    = 16;
  localparam int MID_TICK      = 7;
  localparam int DEFAULT_DBITS = 8;

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RST_VAL so an idle-high line does not look like a
// start bit coming out of reset.
//   clk_50MHz : system clock
//   reset     : synchronous, active-high
//   d         : asynchronous input
//   q         : synchronized output
module rx_synchronizer #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver (8N1 by default) driven by a 16x oversampling tick.
// Recovered bytes sit in a ready/valid holding register; stop-bit errors and
// overwrites of an unconsumed byte are reported as one-cycle pulses.
//   clk_50MHz   : system clock
//   reset       : synchronous, active-high
//   tick        : oversampling strobe, 16 per bit
//   rx          : asynchronous serial input, idles high
//   rx_data     : received byte, valid while rx_valid
//   rx_valid    : holding register full
//   rx_ready    : consumer accepts when rx_valid && rx_ready
//   framing_err : pulse, stop bit sampled low
//   overrun     : pulse, unconsumed byte overwritten
//
// state | meaning
// IDLE  | waiting for a low level on the synchronized line
// START | counting to mid start bit to confirm it
// DATA  | sampling data bits mid-bit, LSB first
// STOP  | counting to mid stop bit, then deliver or flag
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DBITS   = DEFAULT_DBITS,
  parameter int SB_TICK = OVERSAMPLE
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic             tick,
  input  logic             rx,
  output logic [DBITS-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             framing_err,
  output logic             overrun
);

  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [3:0]    S_MID  = 4'(MID_TICK);
  localparam logic [3:0]    S_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);

  logic rx_s;

  uart_state_t      state, state_n;
  logic [3:0]       s, s_n;
  logic [NW-1:0]    n, n_n;
  logic [DBITS-1:0] b, b_n;
  logic             deliver;
  logic             stop_bad;

  rx_synchronizer #(.RST_VAL(1'b1)) u_sync (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .d         (rx),
    .q         (rx_s)
  );

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      b     <= b_n;
    end
  end

  always_comb begin
    state_n  = state;
    s_n      = s;
    n_n      = n;
    b_n      = b;
    deliver  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == S_MID) begin
            // still low at mid start bit: a real start; otherwise a glitch
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == S_LAST) begin
            b_n = {rx_s, b[DBITS-1:1]};
            s_n = '0;
            if (n == N_LAST) begin
              state_n = STOP;
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          // leave at mid stop bit so a back-to-back start edge is not missed
          if (s == S_STOP) begin
            state_n  = IDLE;
            deliver  = rx_s;
            stop_bad = !rx_s;
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= stop_bad;
      // an accept in the same cycle frees the slot, so that is not an overrun
      overrun     <= deliver && rx_valid && !rx_ready;
      if (deliver) begin
        rx_data  <= b;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int M         = 4;    // clocks per tick
  localparam int BIT_CLKS  = 16 * M;
  localparam int STOP_TICK = 8 + 16 * 8 + 16;  // tick index that samples stop bit

  logic       clk_50MHz;
  logic       reset;
  logic       tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       framing_err;
  logic       overrun;

  uart_receiver #(.DBITS(8), .SB_TICK(16)) dut (
    .clk_50MHz   (clk_50MHz),
    .reset       (reset),
    .tick        (tick),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fall_cyc = 0;

  // observed events
  logic [7:0] dlv_q[$];
  int  ferr_cnt = 0;
  int  ovr_cnt  = 0;
  int  vhi_cnt  = 0;
  int  last_dlv_cyc = -1;
  logic pv = 1'b0;
  logic pr = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    logic       ready;
    int         gap;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_dlv;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    clk_50MHz = 1'b0;
    forever #10 clk_50MHz = ~clk_50MHz;
  end

  // one tick every M clocks, tick value in cycle c is (c % M == 0)
  initial begin
    tick = 1'b1;
    forever begin
      @(posedge clk_50MHz);
      #1;
      cyc++;
      tick = (cyc % M == 0);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // a new byte appears when valid is high and the slot was empty, was just
  // accepted, or was overwritten
  initial begin
    forever begin
      @(negedge clk_50MHz);
      if (!reset) begin
        if (rx_valid && (!pv || pr || overrun)) begin
          dlv_q.push_back(rx_data);
          last_dlv_cyc = cyc;
        end
        if (framing_err) ferr_cnt++;
        if (overrun)     ovr_cnt++;
        if (rx_valid)    vhi_cnt++;
      end
      pv = rx_valid;
      pr = rx_ready;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr();
    dlv_q.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
    vhi_cnt  = 0;
  endtask

  task automatic drive_bit(input logic v, input int clks);
    rx = v;
    repeat (clks) @(posedge clk_50MHz);
    #2;
  endtask

  // a bad stop bit is held low only long enough to cover its mid sample
  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    @(posedge clk_50MHz);
    #2;
    fall_cyc = cyc;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
    if (stop_v) begin
      drive_bit(1'b1, BIT_CLKS);
    end else begin
      drive_bit(1'b0, 40);
      drive_bit(1'b1, BIT_CLKS - 40);
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int clks);
    repeat (clks) @(posedge clk_50MHz);
    #2;
  endtask

  // rx low in cycle k -> START entered 3 edges later; stop sample is the
  // STOP_TICK-th tick from then; rx_valid is visible the cycle after it
  function automatic int exp_dlv_cyc(input int k);
    int t0;
    t0 = k + 3;
    while (t0 % M != 0) t0++;
    return t0 + M * (STOP_TICK - 1) + 1;
  endfunction

  logic [7:0] exp_q[$];
  int         exp_ferr;
  logic [7:0] rd;
  logic       rok;
  logic       prev_bad;
  int         gap;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0,   2, 1'b1, 8'hA5, 1, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1,   2, 1'b0, 8'hA5, 0, 1, 0};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 120, 1'b0, 8'h3C, 1, 0, 0};
    vecs[3] = '{8'h11, 1'b1, 1'b0,   2, 1'b1, 8'h11, 1, 0, 0};
    vecs[4] = '{8'h22, 1'b1, 1'b0,   2, 1'b1, 8'h22, 1, 0, 1};
    vecs[5] = '{8'h55, 1'b1, 1'b1,   2, 1'b0, 8'h55, 1, 0, 0};
    vecs[6] = '{8'hAA, 1'b1, 1'b1,   2, 1'b0, 8'hAA, 1, 0, 0};

    reset    = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    idle(4);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset rx_data", rx_data, 0);
    chk("reset framing_err", framing_err, 0);
    chk("reset overrun", overrun, 0);
    reset = 1'b0;
    idle(10);

    for (int i = 0; i < NV; i++) begin
      rx_ready = vecs[i].ready;
      idle(vecs[i].gap);
      clr();
      send_frame(vecs[i].data, vecs[i].stop_v);
      chk($sformatf("v%0d rx_valid", i), rx_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d rx_data", i), rx_data, vecs[i].exp_data);
      chk($sformatf("v%0d deliveries", i), dlv_q.size(), vecs[i].exp_dlv);
      chk($sformatf("v%0d framing_err pulses", i), ferr_cnt, vecs[i].exp_ferr);
      chk($sformatf("v%0d overrun pulses", i), ovr_cnt, vecs[i].exp_ovr);
      if (vecs[i].exp_dlv == 1 && dlv_q.size() == 1) begin
        chk($sformatf("v%0d delivered byte", i), dlv_q[0], vecs[i].data);
        chk($sformatf("v%0d delivery cycle", i), last_dlv_cyc, exp_dlv_cyc(fall_cyc));
      end
      if (vecs[i].ready) chk($sformatf("v%0d valid cycles", i), vhi_cnt, vecs[i].exp_dlv);
    end

    // glitch of 5 ticks, then a real frame
    rx_ready = 1'b1;
    idle(4);
    clr();
    drive_bit(1'b0, 5 * M);
    drive_bit(1'b1, 200);
    chk("glitch deliveries", dlv_q.size(), 0);
    chk("glitch framing_err", ferr_cnt, 0);
    send_frame(8'h3C, 1'b1);
    chk("after glitch deliveries", dlv_q.size(), 1);
    if (dlv_q.size() == 1) chk("after glitch byte", dlv_q[0], 8'h3C);
    chk("after glitch framing_err", ferr_cnt, 0);

    // accept in exactly the delivery cycle
    rx_ready = 1'b0;
    idle(4);
    send_frame(8'h5A, 1'b1);
    chk("held byte", rx_data, 8'h5A);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        int stop_c;
        @(posedge clk_50MHz);
        #3;
        stop_c = exp_dlv_cyc(fall_cyc) - 1;
        while (cyc < stop_c) begin
          @(posedge clk_50MHz);
          #3;
        end
        rx_ready = 1'b1;
        @(posedge clk_50MHz);
        #3;
        rx_ready = 1'b0;
        chk("same-cycle rx_valid", rx_valid, 1);
        chk("same-cycle rx_data", rx_data, 8'hC3);
        chk("same-cycle overrun", overrun, 0);
      end
    join

    // reset in the middle of data bit 4
    idle(4);
    @(posedge clk_50MHz);
    #2;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS / 2);
    reset = 1'b1;
    @(posedge clk_50MHz);
    #2;
    reset = 1'b0;
    rx    = 1'b1;
    @(negedge clk_50MHz);
    chk("mid-frame reset rx_valid", rx_valid, 0);
    chk("mid-frame reset rx_data", rx_data, 0);
    chk("mid-frame reset framing_err", framing_err, 0);
    chk("mid-frame reset overrun", overrun, 0);
    clr();
    idle(300);
    chk("post reset deliveries", dlv_q.size(), 0);
    chk("post reset framing_err", ferr_cnt, 0);
    chk("post reset overrun", ovr_cnt, 0);
    send_frame(8'h0F, 1'b1);
    chk("post reset rx_valid", rx_valid, 1);
    chk("post reset rx_data", rx_data, 8'h0F);

    // random frames against a byte-queue model
    rx_ready = 1'b1;
    idle(4);
    clr();
    exp_q.delete();
    exp_ferr = 0;
    prev_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd  = 8'($urandom_range(0, 255));
      rok = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(1, 80) + (prev_bad ? 120 : 0);
      idle(gap);
      send_frame(rd, rok);
      if (rok) exp_q.push_back(rd);
      else exp_ferr++;
      prev_bad = !rok;
    end
    idle(150);
    chk("random deliveries", dlv_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dlv_q.size(); i++)
      chk($sformatf("random byte %0d", i), dlv_q[i], exp_q[i]);
    chk("random framing_err", ferr_cnt, exp_ferr);
    chk("random overrun", ovr_cnt, 0);
    chk("random valid cycles", vhi_cnt, exp_q.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
